// File: rtl/uart_axi_bridge_if.sv
// AXI4 single-beat initiator/target signal bundle used by the UART debug bridge.
// The ID width is set by the idlen parameter.
interface axi4 #(
  parameter int unsigned idlen = 4
);
  logic [idlen-1:0] aw_id;
  logic [31:0]      aw_addr;
  logic [7:0]       aw_len;
  logic [2:0]       aw_size;
  logic [1:0]       aw_burst;
  logic             aw_valid;
  logic             aw_ready;

  logic [31:0]      w_data;
  logic [3:0]       w_strb;
  logic             w_last;
  logic             w_valid;
  logic             w_ready;

  logic [idlen-1:0] b_id;
  logic [1:0]       b_resp;
  logic             b_valid;
  logic             b_ready;

  logic [idlen-1:0] ar_id;
  logic [31:0]      ar_addr;
  logic [7:0]       ar_len;
  logic [2:0]       ar_size;
  logic [1:0]       ar_burst;
  logic             ar_valid;
  logic             ar_ready;

  logic [idlen-1:0] r_id;
  logic [31:0]      r_data;
  logic [1:0]       r_resp;
  logic             r_last;
  logic             r_valid;
  logic             r_ready;

  modport master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_valid, input aw_ready,
    output w_data, w_strb, w_last, w_valid, input w_ready,
    input  b_id, b_resp, b_valid, output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_valid, input ar_ready,
    input  r_id, r_data, r_resp, r_last, r_valid, output r_ready
  );

  modport slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_valid, output aw_ready,
    input  w_data, w_strb, w_last, w_valid, output w_ready,
    output b_id, b_resp, b_valid, input b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_valid, output ar_ready,
    output r_id, r_data, r_resp, r_last, r_valid, input r_ready
  );
endinterface

// File: rtl/uart_axi_bridge.sv
// UART byte-stream to AXI4 bridge: decodes read/write command frames, issues
// one single-beat 32-bit AXI4 transaction and returns status/data bytes.
module uart_axi_bridge #(
  parameter int unsigned ID      = 0,
  parameter int unsigned TIMEOUT = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  axi4.master        bus,
  input  logic [7:0] rx_d_i,
  input  logic       rx_d_valid_i,
  output logic       rx_d_ready_o,
  output logic [7:0] tx_d_o,
  output logic       tx_d_valid_o,
  input  logic       tx_d_ready_i,
  output logic       busy_o
);

  typedef enum logic [3:0] {
    IDLE, ADDR, DATA, AXI_W, AXI_B, AXI_AR, AXI_R, TX_STATUS, TX_DATA
  } state_t;

  localparam logic [31:0] ID_VEC = ID;

  state_t      state, state_n;
  logic        is_read;
  logic [31:0] addr;
  logic [31:0] data;
  logic [1:0]  byte_cnt;
  logic [7:0]  status;
  logic        aw_done, w_done;
  logic [31:0] tcnt;

  logic rx_fire, tx_fire, aw_fire, w_fire, timeout;
  logic unused_inputs;

  assign rx_d_ready_o = rst_n && (state == IDLE || state == ADDR || state == DATA);
  assign rx_fire      = rx_d_valid_i && rx_d_ready_o;
  assign tx_d_valid_o = (state == TX_STATUS) || (state == TX_DATA);
  assign tx_fire      = tx_d_valid_o && tx_d_ready_i;
  assign busy_o       = (state != IDLE);

  always_comb begin
    tx_d_o = status;
    if (state == TX_DATA) begin
      case (byte_cnt)
        2'd0:    tx_d_o = data[31:24];
        2'd1:    tx_d_o = data[23:16];
        2'd2:    tx_d_o = data[15:8];
        default: tx_d_o = data[7:0];
      endcase
    end
  end

  // Each channel's valid is derived from its own done flag, so AW and W
  // retire independently in any order.
  assign bus.aw_valid = (state == AXI_W) && !aw_done;
  assign bus.w_valid  = (state == AXI_W) && !w_done;
  assign aw_fire      = bus.aw_valid && bus.aw_ready;
  assign w_fire       = bus.w_valid && bus.w_ready;
  assign bus.b_ready  = (state == AXI_B);
  assign bus.ar_valid = (state == AXI_AR);
  assign bus.r_ready  = (state == AXI_R);

  assign bus.aw_id    = ID_VEC[$bits(bus.aw_id)-1:0];
  assign bus.aw_addr  = addr;
  assign bus.aw_len   = '0;
  assign bus.aw_size  = 3'b010;
  assign bus.aw_burst = 2'b01;
  assign bus.w_data   = data;
  assign bus.w_strb   = '1;
  assign bus.w_last   = 1'b1;
  assign bus.ar_id    = ID_VEC[$bits(bus.ar_id)-1:0];
  assign bus.ar_addr  = addr;
  assign bus.ar_len   = '0;
  assign bus.ar_size  = 3'b010;
  assign bus.ar_burst = 2'b01;

  assign unused_inputs = ^{bus.b_id, bus.r_id, bus.r_last};

  assign timeout = (TIMEOUT != 0) && !rx_fire && (tcnt == TIMEOUT - 1);

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (rx_fire)
          state_n = (rx_d_i == 8'h57 || rx_d_i == 8'h52) ? ADDR : TX_STATUS;
      end
      ADDR: begin
        if (rx_fire && byte_cnt == 2'd3) state_n = is_read ? AXI_AR : DATA;
        else if (timeout)                state_n = IDLE;
      end
      DATA: begin
        if (rx_fire && byte_cnt == 2'd3) state_n = AXI_W;
        else if (timeout)                state_n = IDLE;
      end
      AXI_W: begin
        if ((aw_done || aw_fire) && (w_done || w_fire)) state_n = AXI_B;
      end
      AXI_B:     if (bus.b_valid)  state_n = TX_STATUS;
      AXI_AR:    if (bus.ar_ready) state_n = AXI_R;
      AXI_R:     if (bus.r_valid)  state_n = TX_STATUS;
      TX_STATUS: if (tx_fire)      state_n = is_read ? TX_DATA : IDLE;
      TX_DATA:   if (tx_fire && byte_cnt == 2'd3) state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      is_read  <= 1'b0;
      addr     <= '0;
      data     <= '0;
      byte_cnt <= '0;
      status   <= '0;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
      tcnt     <= '0;
    end else begin
      state <= state_n;
      if ((state == ADDR || state == DATA) && !rx_fire) tcnt <= tcnt + 32'd1;
      else                                              tcnt <= '0;
      case (state)
        IDLE: begin
          if (rx_fire) begin
            is_read  <= (rx_d_i == 8'h52);
            status   <= 8'hEE;
            byte_cnt <= '0;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
          end
        end
        ADDR: begin
          if (rx_fire) begin
            addr     <= {addr[23:0], rx_d_i};
            byte_cnt <= byte_cnt + 2'd1;
          end
        end
        DATA: begin
          if (rx_fire) begin
            data     <= {data[23:0], rx_d_i};
            byte_cnt <= byte_cnt + 2'd1;
          end
        end
        AXI_W: begin
          if (aw_fire) aw_done <= 1'b1;
          if (w_fire)  w_done  <= 1'b1;
        end
        AXI_B: if (bus.b_valid) status <= {6'b0, bus.b_resp};
        AXI_R: begin
          if (bus.r_valid) begin
            status <= {6'b0, bus.r_resp};
            data   <= bus.r_data;
          end
        end
        TX_DATA: if (tx_fire) byte_cnt <= byte_cnt + 2'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_axi_bridge.sv
// Directed bench for uart_axi_bridge with a small AXI4 target model driven
// on the falling clock edge.
module tb_uart_axi_bridge;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_d = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_ready;
  logic [7:0] tx_d;
  logic       tx_valid;
  logic       tx_ready = 1'b0;
  logic       busy;

  int unsigned tests = 0;
  int unsigned fails = 0;

  axi4 #(.idlen(4)) bus ();

  uart_axi_bridge #(.ID(5), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .rx_d_i(rx_d), .rx_d_valid_i(rx_valid), .rx_d_ready_o(rx_ready),
    .tx_d_o(tx_d), .tx_d_valid_o(tx_valid), .tx_d_ready_i(tx_ready),
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  // Target model configuration (written by the stimulus only)
  int unsigned aw_delay = 1, w_delay = 1;
  logic [1:0]  b_resp_cfg = 2'b00, r_resp_cfg = 2'b00;
  logic [31:0] r_data_cfg = 32'h0;
  bit          r_block = 1'b0;

  // Target model observations (written by the model only)
  int unsigned aw_count = 0, w_count = 0, ar_count = 0, b_count = 0;
  int unsigned b_issued = 0, r_issued = 0;
  int unsigned aw_hi_cur = 0, w_hi_cur = 0, aw_hi_total = 0, w_hi_total = 0;
  int unsigned valid_cycles = 0;
  bit          b_fire_next = 1'b0, r_fire_next = 1'b0;
  logic [31:0] aw_addr_seen = 32'h0, w_data_seen = 32'h0, ar_addr_seen = 32'h0;
  logic [3:0]  aw_id_seen = 4'h0, ar_id_seen = 4'h0;
  logic [12:0] aw_attr_seen = 13'h0, ar_attr_seen = 13'h0;
  logic [4:0]  w_attr_seen = 5'h0;

  always @(negedge clk) begin
    if (!rst_n) begin
      bus.aw_ready = 1'b0; bus.w_ready = 1'b0; bus.ar_ready = 1'b0;
      bus.b_valid = 1'b0; bus.b_resp = 2'b00; bus.b_id = 4'h0;
      bus.r_valid = 1'b0; bus.r_data = 32'h0; bus.r_resp = 2'b00;
      bus.r_last = 1'b0; bus.r_id = 4'h0;
      b_fire_next = 1'b0; r_fire_next = 1'b0;
      b_issued = aw_count; r_issued = ar_count;
      aw_hi_cur = 0; w_hi_cur = 0;
    end else begin
      if (bus.aw_valid || bus.w_valid || bus.ar_valid) valid_cycles++;
      if (b_fire_next) begin bus.b_valid = 1'b0; b_fire_next = 1'b0; end
      if (!bus.b_valid && aw_count > b_issued && w_count > b_issued) begin
        bus.b_valid = 1'b1; bus.b_resp = b_resp_cfg; bus.b_id = 4'd5; b_issued++;
      end
      if (bus.b_valid && bus.b_ready) begin b_fire_next = 1'b1; b_count++; end

      if (r_fire_next) begin bus.r_valid = 1'b0; r_fire_next = 1'b0; end
      if (!bus.r_valid && !r_block && ar_count > r_issued) begin
        bus.r_valid = 1'b1; bus.r_data = r_data_cfg; bus.r_resp = r_resp_cfg;
        bus.r_last = 1'b1; bus.r_id = 4'd5; r_issued++;
      end
      if (bus.r_valid && bus.r_ready) r_fire_next = 1'b1;

      bus.aw_ready = 1'b0;
      if (bus.aw_valid) begin
        aw_hi_cur++; aw_hi_total++;
        if (aw_hi_cur >= aw_delay) begin
          bus.aw_ready = 1'b1; aw_count++; aw_hi_cur = 0;
          aw_addr_seen = bus.aw_addr; aw_id_seen = bus.aw_id;
          aw_attr_seen = {bus.aw_len, bus.aw_size, bus.aw_burst};
        end
      end
      bus.w_ready = 1'b0;
      if (bus.w_valid) begin
        w_hi_cur++; w_hi_total++;
        if (w_hi_cur >= w_delay) begin
          bus.w_ready = 1'b1; w_count++; w_hi_cur = 0;
          w_data_seen = bus.w_data; w_attr_seen = {bus.w_strb, bus.w_last};
        end
      end
      bus.ar_ready = bus.ar_valid;
      if (bus.ar_valid) begin
        ar_count++; ar_addr_seen = bus.ar_addr; ar_id_seen = bus.ar_id;
        ar_attr_seen = {bus.ar_len, bus.ar_size, bus.ar_burst};
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    rx_d = b; rx_valid = 1'b1;
    while (!rx_ready && n < 100) begin @(negedge clk); n++; end
    if (!rx_ready) check("rx_accept_timeout", 32'(rx_ready), 32'd1);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic recv_byte(input string tag, input logic [7:0] exp);
    logic [7:0] got;
    int n;
    got = 'x; n = 0;
    tx_ready = 1'b1;
    while (!tx_valid && n < 200) begin @(negedge clk); n++; end
    if (tx_valid) begin got = tx_d; @(negedge clk); end
    tx_ready = 1'b0;
    check(tag, 32'(got), 32'(exp));
  endtask

  initial begin
    int unsigned base_aw_hi, base_w_hi, base_valid, stable, n;
    logic [7:0] held;

    // Reset
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'({busy, tx_valid, rx_ready, bus.aw_valid, bus.w_valid,
                                bus.ar_valid, bus.b_ready, bus.r_ready}), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rx_ready_after_reset", 32'({rx_ready, busy}), 32'h2);

    // 1: write 0xDEADBEEF to 0x40000004, OKAY
    send_byte(8'h57); send_byte(8'h40); send_byte(8'h00); send_byte(8'h00); send_byte(8'h04);
    send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
    recv_byte("wr1_status", 8'h00);
    check("wr1_aw_w_count", 32'({aw_count[15:0], w_count[15:0]}), 32'h0001_0001);
    check("wr1_aw_addr", aw_addr_seen, 32'h4000_0004);
    check("wr1_w_data", w_data_seen, 32'hDEAD_BEEF);
    check("wr1_aw_id_attr", 32'({aw_id_seen, aw_attr_seen}), 32'h0000_A009);
    check("wr1_w_strb_last", 32'(w_attr_seen), 32'h1F);
    @(negedge clk);
    check("wr1_idle", 32'(busy), 32'h0);

    // 2: read 0x40000000 -> 0x00010203 OKAY
    r_data_cfg = 32'h0001_0203; r_resp_cfg = 2'b00;
    send_byte(8'h52); send_byte(8'h40); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    recv_byte("rd2_status", 8'h00);
    recv_byte("rd2_d3", 8'h00);
    recv_byte("rd2_d2", 8'h01);
    recv_byte("rd2_d1", 8'h02);
    recv_byte("rd2_d0", 8'h03);
    check("rd2_ar_count", 32'(ar_count), 32'd1);
    check("rd2_ar_addr", ar_addr_seen, 32'h4000_0000);
    check("rd2_ar_id_attr", 32'({ar_id_seen, ar_attr_seen}), 32'h0000_A009);

    // 3: unknown command
    base_valid = valid_cycles;
    send_byte(8'h41);
    recv_byte("unk3_reply", 8'hEE);
    repeat (2) @(negedge clk);
    check("unk3_no_axi", valid_cycles - base_valid, 32'd0);
    check("unk3_idle", 32'(busy), 32'h0);

    // 4: delayed aw_ready, immediate w_ready, SLVERR
    aw_delay = 5; w_delay = 1; b_resp_cfg = 2'b10;
    base_aw_hi = aw_hi_total; base_w_hi = w_hi_total;
    send_byte(8'h57); send_byte(8'h10); send_byte(8'h00); send_byte(8'h00); send_byte(8'h08);
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
    recv_byte("wr4_status", 8'h02);
    check("wr4_aw_hold", aw_hi_total - base_aw_hi, 32'd5);
    check("wr4_w_hold", w_hi_total - base_w_hi, 32'd1);
    check("wr4_b_count", 32'(b_count), 32'd2);
    check("wr4_aw_addr", aw_addr_seen, 32'h1000_0008);
    check("wr4_w_data", w_data_seen, 32'h1234_5678);
    aw_delay = 1; b_resp_cfg = 2'b00;

    // 5: partial frame timeout (TIMEOUT=16), then a normal read
    base_valid = valid_cycles;
    send_byte(8'h57); send_byte(8'h40);
    repeat (15) @(negedge clk);
    check("to5_busy_before", 32'(busy), 32'h1);
    @(negedge clk);
    check("to5_idle_at_limit", 32'(busy), 32'h0);
    repeat (4) @(negedge clk);
    check("to5_no_reply", 32'(tx_valid), 32'h0);
    check("to5_no_axi", valid_cycles - base_valid, 32'd0);
    r_data_cfg = 32'hCAFE_F00D;
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h00); send_byte(8'h01); send_byte(8'h00);
    recv_byte("to5_rd_status", 8'h00);
    recv_byte("to5_rd_d3", 8'hCA);
    recv_byte("to5_rd_d2", 8'hFE);
    recv_byte("to5_rd_d1", 8'hF0);
    recv_byte("to5_rd_d0", 8'h0D);
    check("to5_ar_addr", ar_addr_seen, 32'h0000_0100);

    // 6a: tx back-pressure during read reply
    r_data_cfg = 32'h89AB_CDEF; r_resp_cfg = 2'b01;
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h20);
    n = 0;
    while (!tx_valid && n < 50) begin @(negedge clk); n++; end
    held = tx_d; stable = 0;
    repeat (10) begin
      @(negedge clk);
      if (tx_valid && tx_d == held) stable++;
    end
    check("bp6_held_byte", 32'(held), 32'h01);
    check("bp6_stable_cycles", stable, 32'd10);
    recv_byte("bp6_status", 8'h01);
    recv_byte("bp6_d3", 8'h89);
    recv_byte("bp6_d2", 8'hAB);
    recv_byte("bp6_d1", 8'hCD);
    recv_byte("bp6_d0", 8'hEF);
    r_resp_cfg = 2'b00;

    // 6b: reset while waiting in the read-data phase
    r_block = 1'b1;
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h30);
    n = 0;
    while (!bus.r_ready && n < 50) begin @(negedge clk); n++; end
    check("rst6_in_read_phase", 32'({bus.r_ready, busy}), 32'h3);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst6_outputs", 32'({busy, tx_valid, rx_ready, bus.aw_valid, bus.w_valid,
                               bus.ar_valid, bus.b_ready, bus.r_ready}), 32'h0);
    rst_n = 1'b1; r_block = 1'b0;
    @(negedge clk);
    check("rst6_idle_ready", 32'({rx_ready, busy}), 32'h2);
    r_data_cfg = 32'h0BAD_CAFE;
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h30);
    recv_byte("rst6_rd_status", 8'h00);
    recv_byte("rst6_rd_d3", 8'h0B);
    recv_byte("rst6_rd_d2", 8'hAD);
    recv_byte("rst6_rd_d1", 8'hCA);
    recv_byte("rst6_rd_d0", 8'hFE);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
